// File: rtl/rf_wb_arbiter.sv
// Purpose: round-robin write-back arbiter for the single-port vector register file, plus the pending-write scoreboard.
// Latency: grant to registered write command is 1 cycle; the scoreboard and the conflict pulse are also registered (1 cycle).
// Backpressure: none from the register file. Exactly one valid requester is granted each cycle; the others hold until granted.
module rf_wb_arbiter #(
    parameter int DataWidth  = 32,
    parameter int IndexWidth = 5,
    parameter int NumReq     = 3
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NumReq-1:0]               req_valid,
    output logic [NumReq-1:0]               req_ready,
    input  logic [NumReq*IndexWidth-1:0]    req_addr,
    input  logic [NumReq*4*DataWidth-1:0]   req_data,
    input  logic [NumReq*4-1:0]             req_mask,
    output logic                            wr_en,
    output logic [IndexWidth-1:0]           wr_addr,
    output logic [4*DataWidth-1:0]          wr_data,
    output logic [3:0]                      wr_mask,
    input  logic                            claim_valid,
    input  logic [IndexWidth-1:0]           claim_addr,
    output logic [(2**IndexWidth)-1:0]      busy,
    output logic                            claim_conflict
);

    localparam int PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int NumReg = 2 ** IndexWidth;
    localparam int EntryW = 4 * DataWidth;

    logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  wr_en_q, wr_en_d;
    logic [IndexWidth-1:0] wr_addr_q;
    logic [EntryW-1:0]     wr_data_q;
    logic [3:0]            wr_mask_q;
    logic [NumReg-1:0]     busy_q, busy_d;
    logic                  conflict_q, conflict_d;

    logic [NumReq-1:0]     grant;
    logic                  any_gnt;
    int                    win_idx;
    logic [IndexWidth-1:0] win_addr;
    logic [EntryW-1:0]     win_data;
    logic [3:0]            win_mask;
    logic [NumReg-1:0]     set_vec, clr_vec;
    logic                  claim_hit;

    // Round-robin pick: scan from rr_ptr upward (wrapping), first valid wins; nothing is granted while in reset.
    always_comb begin
        int idx;
        grant   = '0;
        any_gnt = 1'b0;
        win_idx = 0;
        idx     = 0;
        for (int k = 0; k < NumReq; k++) begin
            idx = (int'(rr_ptr_q) + k) % NumReq;
            if (rstn && !any_gnt && req_valid[idx]) begin
                any_gnt    = 1'b1;
                grant[idx] = 1'b1;
                win_idx    = idx;
            end
        end
    end

    assign req_ready = grant;
    assign win_addr  = req_addr[win_idx*IndexWidth +: IndexWidth];
    assign win_data  = req_data[win_idx*EntryW +: EntryW];
    assign win_mask  = req_mask[win_idx*4 +: 4];

    // Next pointer sits just past the winner; an idle cycle leaves it alone.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_gnt) begin
            rr_ptr_d = PtrW'((win_idx + 1) % NumReq);
        end
    end

    // Writes to r0 or with an empty lane mask are consumed but never reach the register file.
    assign wr_en_d = any_gnt && (win_addr != '0) && (win_mask != 4'b0000);

    // Scoreboard: clear on any granted write, then set on a claim so a fresh producer wins the tie; r0 never busy.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (any_gnt) begin
            clr_vec[win_addr] = 1'b1;
        end
        if (claim_valid && (claim_addr != '0)) begin
            set_vec[claim_addr] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    // A claim conflicts only if the register stays in flight, i.e. it is not retiring in this same cycle.
    assign claim_hit  = claim_valid && (claim_addr != '0) && busy_q[claim_addr];
    assign conflict_d = claim_hit && !(any_gnt && (win_addr == claim_addr));

    // Pointer, scoreboard and conflict pulse registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q   <= '0;
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    // Registered write command: payload loads on every grant (dropped ones too), holds when idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_mask_q <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            if (any_gnt) begin
                wr_addr_q <= win_addr;
                wr_data_q <= win_data;
                wr_mask_q <= win_mask;
            end
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign wr_mask        = wr_mask_q;
    assign busy           = busy_q;
    assign claim_conflict = conflict_q;

endmodule
